rst_sequencer: RTL and testbench
================================

Name: rst_sequencer

Overview:
- Sits inside top_level and consumes the board/bench `clk` and `reset`.
- Synchronizes reset deassertion and stretches it to a minimum hold time.
- Releases NUM_STAGES downstream active-high resets in order, with a fixed gap between stages.
- Accepts software reset requests once running, and reports a ready flag, the last reset cause and a soft-reset count.

Parameters:
- NUM_STAGES, 3: number of sequenced reset outputs; legal 1..8.
- HOLD_CYCLES, 16: clk cycles all stages stay asserted after synchronized release or soft request; legal >= 1.
- STAGE_GAP, 4: clk cycles between successive stage releases; legal >= 1.
- CNT_W, 8: width of the soft-reset counter.

Ports:
- clk, input, 1: single clock for the whole block.
- reset, input, 1: asynchronous, active-low reset; 0 = in reset.
- sw_rst_req, input, 1: software reset request, level-sampled on the rising edge of clk.
- rst_out, output, NUM_STAGES: active-high resets; bit 0 releases first.
- ready, output, 1: high when all stages are released and FSM is in RUN.
- rst_cause, output, 2: cause of the last reset; 2'b01 = external, 2'b10 = soft; 00 and 11 are unused.
- soft_rst_count, output, CNT_W: number of accepted soft resets, saturating.

Behaviour:
- Reset asserted (reset=0), asynchronous and immediate:
  - rst_out all 1, ready 0, rst_cause 2'b01, soft_rst_count 0.
  - Synchronizer flops 0, FSM in HOLD, counters 0.
- Deassertion path:
  - reset goes through a 2-flop synchronizer.
  - Sync output goes 1 at the 2nd rising edge after reset goes high (E1, with E0 the first edge where reset=1).
- FSM states: HOLD, STRETCH, RELEASE, RUN.
- HOLD: all rst_out=1. Leave HOLD when sync=1, entering STRETCH with cnt=0 on edge E2.
- STRETCH: cnt increments each edge. When cnt==HOLD_CYCLES-1, go to RELEASE, clear rst_out[0], set stage=1, cnt=0.
  - Requirement: rst_out[0] falls at edge E(2+HOLD_CYCLES).
- RELEASE: cnt increments. When cnt==STAGE_GAP-1, clear rst_out[stage], stage++, cnt=0.
  - rst_out[k] falls at edge E(2+HOLD_CYCLES+k*STAGE_GAP).
  - After the last stage is released, the next edge goes to RUN and sets ready=1.
  - NUM_STAGES=1: go straight from STRETCH to RUN one edge after rst_out[0] falls.
- RUN, sw_rst_req=1 sampled:
  - Next edge: rst_out all 1, ready 0, rst_cause 2'b10, soft_rst_count +1 (saturates at all-ones, no wrap).
  - Enter STRETCH with cnt=0; the synchronizer is not involved.
  - rst_out[0] falls HOLD_CYCLES edges after entry, then the same stage spacing applies.
- sw_rst_req outside RUN: ignored; not queued, not counted.
- sw_rst_req held high continuously: one request is accepted per visit to RUN. The next request can be taken on the first RUN cycle after a full sequence.
- Reset asserted mid-sequence or in RUN:
  - Immediate return to HOLD with full reset values.
  - soft_rst_count clears; rst_cause=01.
- Reset pulse shorter than one clk period: still resets fully (asynchronous), then a full sequence runs.
- rst_out is monotonic within a sequence: once released, a bit stays 0 until the next reset or soft request.
- All outputs are registered; no combinational path from any input to any output.
- Stage counter width is clog2(NUM_STAGES+1); cnt width is clog2(max(HOLD_CYCLES, STAGE_GAP)).

Decomposition:
- Package rst_seq_pkg:
  - FSM state encoding (HOLD, STRETCH, RELEASE, RUN).
  - Cause codes CAUSE_EXT=2'b01 and CAUSE_SOFT=2'b10.
  - clog2 helper function.
- Sub-module rst_sync_2ff: async active-low clear, 2 flops, input tied high, output = synchronized release.
- The FSM, counters and outputs stay in rst_sequencer.

Test Plan (defaults NUM_STAGES=3, HOLD_CYCLES=16, STAGE_GAP=4, clk period 20):
- Power-up: hold reset=0 for 100, release.
  - Edges counted from E0: rst_out=3'b111 through E17; rst_out[0]=0 at E18, [1]=0 at E22, [2]=0 at E26.
  - ready=1 at E27; rst_cause=01; count=0.
- Soft reset: once in RUN, 1-cycle sw_rst_req.
  - Next edge: rst_out=111, ready=0, rst_cause=10, count=1.
  - Stage 0 release 16 edges later, stages 1/2 at +4/+8, ready at +9.
- Ignored request: assert sw_rst_req during STRETCH and during RELEASE.
  - Sequence timing unchanged; count unchanged.
- Mid-sequence reset: pull reset=0 for 5 ns between E20 and E21.
  - rst_out=111 and ready=0 immediately, count=0.
  - After release, the full power-up timing repeats from a new E0.
- Saturation: CNT_W=2, issue 5 soft resets → count reads 1,2,3,3,3.
- Level request: hold sw_rst_req high for 200 cycles → exactly one soft reset per completed sequence; ready pulses 1 cycle between them.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM states, reset-cause
// codes and an elaboration-time clog2.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

  localparam logic [1:0] CAUSE_EXT  = 2'b01;
  localparam logic [1:0] CAUSE_SOFT = 2'b10;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rst_sync_2ff.sv
// Two-flop release synchronizer: asserts asynchronously, releases two clk
// edges after rst_n rises.
module rst_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  output logic sync_out
);

  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= sync_d;
  end

  assign sync_out = sync_q[1];

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: stretches a synchronized release, then drops NUM_STAGES
// active-high resets in order with a fixed gap; accepts soft resets in RUN.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sw_rst_req,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  ready,
  output logic [1:0]            rst_cause,
  output logic [CNT_W-1:0]      soft_rst_count
);

  localparam int CMAX   = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CW_RAW = clog2(CMAX);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam int SW     = clog2(NUM_STAGES + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [SW-1:0] STAGE_N   = SW'(NUM_STAGES);

  logic sync_rel;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SW-1:0]         stage_q, stage_d;
  logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
  logic                  ready_q, ready_d;
  logic [1:0]            cause_q, cause_d;
  logic [CNT_W-1:0]      count_q, count_d;

  rst_sync_2ff u_sync (
    .clk      (clk),
    .rst_n    (reset),
    .sync_out (sync_rel)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stage_d   = stage_q;
    rst_out_d = rst_out_q;
    ready_d   = ready_q;
    cause_d   = cause_q;
    count_d   = count_q;

    case (state_q)
      ST_HOLD: begin
        rst_out_d = '1;
        ready_d   = 1'b0;
        if (sync_rel) begin
          state_d = ST_STRETCH;
          cnt_d   = '0;
        end
      end

      ST_STRETCH: begin
        if (cnt_q == HOLD_LAST) begin
          state_d      = ST_RELEASE;
          rst_out_d[0] = 1'b0;
          stage_d      = SW'(1);
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_RELEASE: begin
        // One extra edge after the last stage drops before ready rises.
        if (stage_q == STAGE_N) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          for (int i = 0; i < NUM_STAGES; i++) begin
            if (stage_q == SW'(i)) rst_out_d[i] = 1'b0;
          end
          stage_d = stage_q + SW'(1);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_RUN: begin
        if (sw_rst_req) begin
          state_d   = ST_STRETCH;
          cnt_d     = '0;
          rst_out_d = '1;
          ready_d   = 1'b0;
          cause_d   = CAUSE_SOFT;
          count_d   = (&count_q) ? count_q : count_q + CNT_W'(1);
        end
      end

      default: state_d = ST_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_HOLD;
      cnt_q     <= '0;
      stage_q   <= '0;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
      cause_q   <= CAUSE_EXT;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stage_q   <= stage_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
      cause_q   <= cause_d;
      count_q   <= count_d;
    end
  end

  assign rst_out        = rst_out_q;
  assign ready          = ready_q;
  assign rst_cause      = cause_q;
  assign soft_rst_count = count_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: a default instance and a small saturating instance,
// both checked every cycle against an age-based timing model.
module tb_rst_sequencer;

  localparam int N0 = 3, H0 = 16, G0 = 4, C0 = 8;
  localparam int N1 = 1, H1 = 3,  G1 = 2, C1 = 2;

  logic clk = 1'b0, reset = 1'b0, sw0 = 1'b0, sw1 = 1'b0;
  logic [N0-1:0] rst_out0; logic ready0; logic [1:0] cause0; logic [C0-1:0] cnt0;
  logic [N1-1:0] rst_out1; logic ready1; logic [1:0] cause1; logic [C1-1:0] cnt1;

  int checks = 0, failures = 0;

  // Model: age = edges since stage-hold began (-1 while waiting on sync).
  int         m_age[2], m_wait[2], m_cnt[2];
  logic [1:0] m_cause[2];
  logic [7:0] e_rst[2];
  logic       e_rdy[2];

  always #10 clk = ~clk;

  rst_sequencer #(.NUM_STAGES(N0), .HOLD_CYCLES(H0), .STAGE_GAP(G0), .CNT_W(C0)) dut0 (
    .clk(clk), .reset(reset), .sw_rst_req(sw0),
    .rst_out(rst_out0), .ready(ready0), .rst_cause(cause0), .soft_rst_count(cnt0));

  rst_sequencer #(.NUM_STAGES(N1), .HOLD_CYCLES(H1), .STAGE_GAP(G1), .CNT_W(C1)) dut1 (
    .clk(clk), .reset(reset), .sw_rst_req(sw1),
    .rst_out(rst_out1), .ready(ready1), .rst_cause(cause1), .soft_rst_count(cnt1));

  function automatic int pn(input int i);   return (i == 0) ? N0 : N1; endfunction
  function automatic int ph(input int i);   return (i == 0) ? H0 : H1; endfunction
  function automatic int pg(input int i);   return (i == 0) ? G0 : G1; endfunction
  function automatic int pmax(input int i); return (i == 0) ? (1 << C0) - 1 : (1 << C1) - 1; endfunction
  function automatic int rdy_age(input int i); return ph(i) + (pn(i) - 1) * pg(i) + 1; endfunction

  function automatic void model_out();
    for (int i = 0; i < 2; i++) begin
      e_rdy[i] = (m_age[i] >= rdy_age(i));
      e_rst[i] = '0;
      for (int k = 0; k < pn(i); k++) e_rst[i][k] = (m_age[i] < ph(i) + k * pg(i));
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_age[i] = -1; m_wait[i] = 3; m_cnt[i] = 0; m_cause[i] = 2'b01;
    end
    model_out();
  endfunction

  function automatic void model_edge(input int i, input logic r);
    if (m_age[i] >= rdy_age(i) && r) begin
      m_age[i] = 0;
      m_cause[i] = 2'b10;
      if (m_cnt[i] < pmax(i)) m_cnt[i]++;
    end else if (m_wait[i] > 0) begin
      m_wait[i]--;
      if (m_wait[i] == 0) m_age[i] = 0;
    end else if (m_age[i] >= 0 && m_age[i] < 1000000) begin
      m_age[i]++;
    end
  endfunction

  function automatic logic [N0+2+C0:0] obs0(); return {rst_out0, ready0, cause0, cnt0}; endfunction
  function automatic logic [N0+2+C0:0] exp0(); return {e_rst[0][N0-1:0], e_rdy[0], m_cause[0], C0'(m_cnt[0])}; endfunction
  function automatic logic [N1+2+C1:0] obs1(); return {rst_out1, ready1, cause1, cnt1}; endfunction
  function automatic logic [N1+2+C1:0] exp1(); return {e_rst[1][N1-1:0], e_rdy[1], m_cause[1], C1'(m_cnt[1])}; endfunction

  task automatic tick(input logic r0, input logic r1);
    sw0 = r0; sw1 = r1;
    @(posedge clk);
    model_edge(0, r0);
    model_edge(1, r1);
    model_out();
    #1;
  endtask

  task automatic wait_rdy(input int i, input string nm);
    int n = 0;
    while (!((i == 0) ? ready0 : ready1) && n < 200) begin
      tick(1'b0, 1'b0);
      n++;
    end
    checks++;
    if (((i == 0) ? ready0 : ready1) !== e_rdy[i]) begin
      failures++;
      $display("FAIL %s wait_ready inst%0d got=%b exp=%b after %0d cycles", nm, i,
               (i == 0) ? ready0 : ready1, e_rdy[i], n);
    end
  endtask

  task automatic test_reset();
    #50;
    checks++;
    if ({obs0(), obs1()} !== {3'b111, 1'b0, 2'b01, 8'd0, 1'b1, 1'b0, 2'b01, 2'd0}) begin
      failures++;
      $display("FAIL reset_state got=%b/%b exp=111_0_01_0/1_0_01_0", obs0(), obs1());
    end
    #50;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_powerup();
    for (int c = 0; c < 30; c++) begin
      tick(1'b0, 1'b0);
      checks++;
      if (obs0() !== exp0()) begin
        failures++;
        $display("FAIL powerup0 E%0d got=%b exp=%b", c, obs0(), exp0());
      end
      checks++;
      if (obs1() !== exp1()) begin
        failures++;
        $display("FAIL powerup1 E%0d got=%b exp=%b", c, obs1(), exp1());
      end
      if (c == 17 || c == 18 || c == 22 || c == 26 || c == 27) begin
        checks++;
        if ({rst_out0, ready0} !== ((c == 17) ? 4'b1110 : (c == 18) ? 4'b1100 :
                                    (c == 22) ? 4'b1000 : (c == 26) ? 4'b0000 : 4'b0001)) begin
          failures++;
          $display("FAIL powerup_edge E%0d got rst=%b rdy=%b", c, rst_out0, ready0);
        end
      end
    end
  endtask

  task automatic test_soft();
    wait_rdy(0, "soft");
    tick(1'b1, 1'b0);
    checks++;
    if ({rst_out0, ready0, cause0, cnt0} !== {3'b111, 1'b0, 2'b10, 8'd1}) begin
      failures++;
      $display("FAIL soft_entry got=%b exp=111_0_10_00000001", obs0());
    end
    for (int c = 1; c <= 26; c++) begin
      tick(1'b0, 1'b0);
      checks++;
      if (obs0() !== exp0()) begin
        failures++;
        $display("FAIL soft cyc=%0d got=%b exp=%b", c, obs0(), exp0());
      end
    end
  endtask

  task automatic test_ignored();
    int base;
    wait_rdy(0, "ignored");
    tick(1'b1, 1'b0);
    base = m_cnt[0];
    for (int c = 1; c <= 30; c++) begin
      tick((c == 5 || c == 20 || c == 21), 1'b0);
      checks++;
      if (obs0() !== exp0()) begin
        failures++;
        $display("FAIL ignored cyc=%0d got=%b exp=%b", c, obs0(), exp0());
      end
    end
    checks++;
    if (cnt0 !== C0'(base)) begin
      failures++;
      $display("FAIL ignored_count got=%0d exp=%0d", cnt0, base);
    end
  endtask

  task automatic test_mid_reset();
    reset = 1'b0; #5; reset = 1'b1;
    model_reset();
    for (int c = 0; c <= 20; c++) tick(1'b0, 1'b0);
    #4 reset = 1'b0;
    #2;
    checks++;
    if ({obs0(), obs1()} !== {3'b111, 1'b0, 2'b01, 8'd0, 1'b1, 1'b0, 2'b01, 2'd0}) begin
      failures++;
      $display("FAIL mid_reset_async got=%b/%b exp=111_0_01_0/1_0_01_0", obs0(), obs1());
    end
    #3 reset = 1'b1;
    model_reset();
    for (int c = 0; c < 30; c++) begin
      tick(1'b0, 1'b0);
      checks++;
      if (obs0() !== exp0()) begin
        failures++;
        $display("FAIL mid_reset_seq0 E%0d got=%b exp=%b", c, obs0(), exp0());
      end
      checks++;
      if (obs1() !== exp1()) begin
        failures++;
        $display("FAIL mid_reset_seq1 E%0d got=%b exp=%b", c, obs1(), exp1());
      end
    end
  endtask

  task automatic test_saturation();
    int sat_exp[5] = '{1, 2, 3, 3, 3};
    for (int n = 0; n < 5; n++) begin
      wait_rdy(1, "saturation");
      tick(1'b0, 1'b1);
      checks++;
      if (cnt1 !== C1'(sat_exp[n])) begin
        failures++;
        $display("FAIL saturation req=%0d got=%0d exp=%0d", n, cnt1, sat_exp[n]);
      end
      checks++;
      if (obs1() !== exp1()) begin
        failures++;
        $display("FAIL saturation_state req=%0d got=%b exp=%b", n, obs1(), exp1());
      end
    end
  endtask

  task automatic test_level();
    int base, pulses, exp_n;
    logic prev;
    wait_rdy(0, "level");
    base   = m_cnt[0];
    pulses = 0;
    prev   = 1'b0;
    exp_n  = (200 - 1) / (rdy_age(0) + 1) + 1;
    for (int c = 0; c < 200; c++) begin
      if (ready0) pulses++;
      checks++;
      if (ready0 && prev) begin
        failures++;
        $display("FAIL level_pulse_width cyc=%0d got=ready high twice exp=single cycle", c);
      end
      prev = ready0;
      tick(1'b1, 1'b0);
      checks++;
      if (obs0() !== exp0()) begin
        failures++;
        $display("FAIL level cyc=%0d got=%b exp=%b", c, obs0(), exp0());
      end
    end
    checks++;
    if (cnt0 !== C0'(base + exp_n) || pulses != exp_n) begin
      failures++;
      $display("FAIL level_count got=%0d pulses=%0d exp=%0d pulses=%0d", cnt0, pulses, base + exp_n, exp_n);
    end
    sw0 = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      tick(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
      checks++;
      if (obs0() !== exp0()) begin
        failures++;
        $display("FAIL random0 cyc=%0d got=%b exp=%b", c, obs0(), exp0());
      end
      checks++;
      if (obs1() !== exp1()) begin
        failures++;
        $display("FAIL random1 cyc=%0d got=%b exp=%b", c, obs1(), exp1());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_powerup();
    test_soft();
    test_ignored();
    test_mid_reset();
    test_saturation();
    test_level();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
